// File: rtl/fast_mean.sv
// fast_mean: sample-mean stage of the one-unit FastICA datapath.
// Accumulates 2^N_LOG2 signed samples from the multiplier stages and hands one
// signed mean word to mul5 over a valid/ready handshake.
// go_fast is a synchronous active-low reset.
// Optional build macro FAST_MEAN_ROUND_EN: round half-up with +max saturation
// instead of plain arithmetic-shift truncation. Latency is the same either way.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for en_mean; nothing accepted
// S_ACCUM | accepting samples, summing into acc_q
// S_HOLD  | mean word presented, waiting for mean_ready
// S_DONE  | window finished; waits for en_mean low before re-arming
module fast_mean #(
    parameter int DATA_W = 16,
    parameter int N_LOG2 = 7,
    parameter int ACC_W  = DATA_W + N_LOG2
) (
    input  logic              clk_mean,
    input  logic              go_fast,
    input  logic              en_mean,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mean_valid,
    output logic [DATA_W-1:0] mean_data,
    input  logic              mean_ready,
    output logic              mean_busy,
    output logic [N_LOG2:0]   sample_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Count value just before the final sample of the window is accepted.
    localparam logic [N_LOG2:0] CNT_LAST = {1'b0, {N_LOG2{1'b1}}};

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [N_LOG2:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]  mean_q, mean_d;

    logic [ACC_W-1:0]   sample_ext;
    logic [ACC_W-1:0]   sum_next;
    logic [DATA_W-1:0]  mean_calc;

    assign sample_ext = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
    assign sum_next   = acc_q + sample_ext;

`ifdef FAST_MEAN_ROUND_EN
    // Half-LSB of the result, added one bit wider so +full-scale cannot wrap.
    localparam logic signed [ACC_W:0] RND_K =
        {{(ACC_W+1-N_LOG2){1'b0}}, 1'b1, {(N_LOG2-1){1'b0}}};
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};

    logic signed [ACC_W:0] sum_rnd;
    logic signed [ACC_W:0] rnd_sh;

    // Rounded mean; only the positive end can exceed DATA_W after rounding.
    always_comb begin
        sum_rnd = $signed({sum_next[ACC_W-1], sum_next}) + RND_K;
        rnd_sh  = sum_rnd >>> N_LOG2;
        if (rnd_sh > SAT_MAX) begin
            mean_calc = {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            mean_calc = rnd_sh[DATA_W-1:0];
        end
    end
`else
    // Truncating mean: dropping the low N_LOG2 bits is an arithmetic shift.
    assign mean_calc = sum_next[N_LOG2 +: DATA_W];
`endif

    // State register with synchronous abort; partial sums are discarded.
    always_ff @(posedge clk_mean) begin
        if (!go_fast) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            mean_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mean_q  <= mean_d;
        end
    end

    // Next-state, accumulate and mean capture.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mean_d  = mean_q;
        case (state_q)
            S_IDLE: begin
                if (en_mean) begin
                    state_d = S_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    acc_d = sum_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        mean_d  = mean_calc;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (mean_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!en_mean) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready   = (state_q == S_ACCUM);
    assign mean_valid = (state_q == S_HOLD);
    assign mean_busy  = (state_q == S_ACCUM) || (state_q == S_HOLD);
    assign mean_data  = mean_q;
    assign sample_cnt = cnt_q;

endmodule
